// File: rtl/arith_pkg.sv
// rtl/arith_pkg.sv - shared arithmetic datapath types and default widths
package arith_pkg;

    localparam int DIVIDEND_W = 64;
    localparam int DIVISOR_W  = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/seq_divider_if.sv
// rtl/seq_divider_if.sv - start/done handshake and operand/result bundle for seq_divider
interface seq_divider_if #(
    parameter int DIVIDEND_W = arith_pkg::DIVIDEND_W,
    parameter int DIVISOR_W  = arith_pkg::DIVISOR_W
);

    logic                  start;
    logic [DIVIDEND_W-1:0] dividend;
    logic [DIVISOR_W-1:0]  divisor;
    logic                  busy;
    logic                  done;
    logic [DIVIDEND_W-1:0] quotient;
    logic [DIVISOR_W-1:0]  remainder;
    logic                  div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );

endinterface

// File: rtl/seq_divider_div_step.sv
// rtl/seq_divider_div_step.sv - one restoring-division iteration (shift, compare, subtract)
module div_step #(
    parameter int DIVIDEND_W = arith_pkg::DIVIDEND_W,
    parameter int DIVISOR_W  = arith_pkg::DIVISOR_W
) (
    input  logic [DIVISOR_W:0]    p,
    input  logic [DIVIDEND_W-1:0] dq,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic [DIVISOR_W:0]    p_next,
    output logic [DIVIDEND_W-1:0] dq_next
);

    logic [DIVISOR_W:0] p_shift;
    logic [DIVISOR_W:0] d_ext;
    logic               ge;

    // The dividend bits feed the partial remainder from the top while quotient bits enter at the bottom.
    always_comb begin
        p_shift = {p[DIVISOR_W-1:0], dq[DIVIDEND_W-1]};
        d_ext   = {1'b0, divisor};
        ge      = (p_shift >= d_ext);
        p_next  = ge ? (p_shift - d_ext) : p_shift;
        dq_next = {dq[DIVIDEND_W-2:0], ge};
    end

endmodule

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - iterative radix-2 restoring divider; SEQ_DIVIDER_SIGNED_EN selects signed operands
module seq_divider #(
    parameter int DIVIDEND_W = arith_pkg::DIVIDEND_W,
    parameter int DIVISOR_W  = arith_pkg::DIVISOR_W,
    parameter int CNT_W      = 7
) (
    input  logic           clk,
    input  logic           rst_n,
    seq_divider_if.slave   bus
);

    import arith_pkg::*;

    state_t                state;
    state_t                state_next;
    logic [DIVIDEND_W-1:0] dq;
    logic [DIVIDEND_W-1:0] dq_next;
    logic [DIVISOR_W:0]    p;
    logic [DIVISOR_W:0]    p_next;
    logic [DIVISOR_W-1:0]  dsr;
    logic [CNT_W-1:0]      cnt;
    logic [DIVIDEND_W-1:0] quotient_r;
    logic [DIVISOR_W-1:0]  remainder_r;
    logic                  dbz_r;
    logic                  last_iter;
    logic [DIVIDEND_W-1:0] a_op;
    logic [DIVISOR_W-1:0]  b_op;
    logic [DIVIDEND_W-1:0] zero_quot;

`ifdef SEQ_DIVIDER_SIGNED_EN
    logic neg_q;
    logic neg_r;

    // The unsigned core works on magnitudes; signs are restored in FIX.
    always_comb begin
        a_op      = bus.dividend[DIVIDEND_W-1] ? -bus.dividend : bus.dividend;
        b_op      = bus.divisor[DIVISOR_W-1]   ? -bus.divisor  : bus.divisor;
        zero_quot = bus.dividend[DIVIDEND_W-1] ? DIVIDEND_W'(1) : '1;
    end
`else
    // Unsigned build passes operands straight through.
    always_comb begin
        a_op      = bus.dividend;
        b_op      = bus.divisor;
        zero_quot = '1;
    end
`endif

    assign last_iter = (cnt == CNT_W'(1));

    div_step #(
        .DIVIDEND_W (DIVIDEND_W),
        .DIVISOR_W  (DIVISOR_W)
    ) u_div_step (
        .p       (p),
        .dq      (dq),
        .divisor (dsr),
        .p_next  (p_next),
        .dq_next (dq_next)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state logic; a zero divisor skips the iteration entirely.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (bus.start) state_next = (bus.divisor == '0) ? DONE : RUN;
            RUN: begin
                if (last_iter) begin
`ifdef SEQ_DIVIDER_SIGNED_EN
                    state_next = FIX;
`else
                    state_next = DONE;
`endif
                end
            end
            FIX:     state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operand capture, iteration and result registers; results change only on entry to DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dq          <= '0;
            p           <= '0;
            dsr         <= '0;
            cnt         <= '0;
            quotient_r  <= '0;
            remainder_r <= '0;
            dbz_r       <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        dq  <= a_op;
                        dsr <= b_op;
                        p   <= '0;
                        cnt <= CNT_W'(DIVIDEND_W);
`ifdef SEQ_DIVIDER_SIGNED_EN
                        neg_q <= bus.dividend[DIVIDEND_W-1] ^ bus.divisor[DIVISOR_W-1];
                        neg_r <= bus.dividend[DIVIDEND_W-1];
`endif
                        if (bus.divisor == '0) begin
                            quotient_r  <= zero_quot;
                            remainder_r <= bus.dividend[DIVISOR_W-1:0];
                            dbz_r       <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    dq  <= dq_next;
                    p   <= p_next;
                    cnt <= cnt - CNT_W'(1);
`ifndef SEQ_DIVIDER_SIGNED_EN
                    if (last_iter) begin
                        quotient_r  <= dq_next;
                        remainder_r <= p_next[DIVISOR_W-1:0];
                        dbz_r       <= 1'b0;
                    end
`endif
                end
`ifdef SEQ_DIVIDER_SIGNED_EN
                FIX: begin
                    quotient_r  <= neg_q ? -dq : dq;
                    remainder_r <= neg_r ? -p[DIVISOR_W-1:0] : p[DIVISOR_W-1:0];
                    dbz_r       <= 1'b0;
                end
`endif
                default: ;
            endcase
        end
    end

    assign bus.busy        = (state != IDLE);
    assign bus.done        = (state == DONE);
    assign bus.quotient    = quotient_r;
    assign bus.remainder   = remainder_r;
    assign bus.div_by_zero = dbz_r;

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - scoreboard bench for seq_divider (honours SEQ_DIVIDER_SIGNED_EN)
module tb_seq_divider;

`ifdef SEQ_DIVIDER_SIGNED_EN
    localparam int LAT = 66;
`else
    localparam int LAT = 65;
`endif

    typedef struct {
        logic [63:0] q;
        logic [31:0] r;
        logic        z;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   acc = 0;
    exp_t sb[$];
    exp_t last;

    seq_divider_if #(.DIVIDEND_W(64), .DIVISOR_W(32)) bus ();

    seq_divider #(.DIVIDEND_W(64), .DIVISOR_W(32), .CNT_W(7)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model(input logic [63:0] a, input logic [31:0] b,
                         output logic [63:0] q, output logic [31:0] r, output logic z);
        logic [63:0] t;
        z = (b == 32'd0);
`ifdef SEQ_DIVIDER_SIGNED_EN
        if (z) begin
            q = a[63] ? 64'd1 : '1;
            r = a[31:0];
        end else begin
            q = 64'($signed(a) / $signed({{32{b[31]}}, b}));
            t = 64'($signed(a) % $signed({{32{b[31]}}, b}));
            r = t[31:0];
        end
`else
        if (z) begin
            q = '1;
            r = a[31:0];
        end else begin
            q = a / {32'd0, b};
            t = a % {32'd0, b};
            r = t[31:0];
        end
`endif
    endtask

    task automatic start_op(input logic [63:0] a, input logic [31:0] b);
        exp_t e;
        model(a, b, e.q, e.r, e.z);
        e.lat = (b == 32'd0) ? 1 : LAT;
        sb.push_back(e);
        bus.dividend = a;
        bus.divisor  = b;
        bus.start    = 1'b1;
        @(posedge clk);
        #1;
        acc = cyc;
        bus.start = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.done && n < 300);
        last = sb.pop_front();
        check("done_seen", 64'(bus.done), 64'd1);
        if (bus.done) begin
            check("quotient", bus.quotient, last.q);
            check("remainder", 64'(bus.remainder), 64'(last.r));
            check("div_by_zero", 64'(bus.div_by_zero), 64'(last.z));
            check("latency", 64'(cyc - acc + 1), 64'(last.lat));
        end
    endtask

    task automatic post_check();
        @(negedge clk);
        check("done_pulse", 64'(bus.done), 64'd0);
        check("busy_idle", 64'(bus.busy), 64'd0);
        check("q_held", bus.quotient, last.q);
    endtask

    task automatic run_op(input logic [63:0] a, input logic [31:0] b);
        start_op(a, b);
        check("busy_run", 64'(bus.busy), 64'd1);
        wait_done();
        post_check();
    endtask

    initial begin
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        #2;
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_q", bus.quotient, 64'd0);
        check("rst_r", 64'(bus.remainder), 64'd0);
        check("rst_dbz", 64'(bus.div_by_zero), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(64'h0000_0003_0B12_7D11, 32'd385);
        check("spec_q", bus.quotient, 64'd33949773);
        check("spec_r", 64'(bus.remainder), 64'd324);
        run_op(64'd100, 32'd7);
        run_op(64'hFFFF_FFFF_FFFF_FFFF, 32'd1);
        run_op(64'h1234, 32'd0);
        run_op(64'd100, 32'd7);
        for (int i = 0; i < 4; i++)
            run_op({$urandom, $urandom}, $urandom | 32'd1);

        // Start with new operands mid-run must be ignored.
        start_op(64'd1000, 32'd10);
        repeat (9) @(negedge clk);
        bus.dividend = 64'd77;
        bus.divisor  = 32'd0;
        bus.start    = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("busy_ignored", 64'(bus.busy), 64'd1);
        wait_done();
        post_check();

        // Start held during the done cycle is not accepted.
        start_op(64'd100, 32'd7);
        wait_done();
        bus.dividend = 64'd55;
        bus.divisor  = 32'd0;
        bus.start    = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("done_start_busy", 64'(bus.busy), 64'd0);
        @(negedge clk);
        check("done_start_busy2", 64'(bus.busy), 64'd0);
        check("done_start_dbz", 64'(bus.div_by_zero), 64'd0);

        // Reset mid-operation abandons the run.
        start_op(64'd123456789, 32'd1000);
        repeat (29) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_q", bus.quotient, 64'd0);
        check("mid_rst_r", 64'(bus.remainder), 64'd0);
        check("mid_rst_busy", 64'(bus.busy), 64'd0);
        void'(sb.pop_front());
        repeat (3) begin
            @(negedge clk);
            check("mid_rst_done", 64'(bus.done), 64'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        run_op(64'd100, 32'd7);

`ifdef SEQ_DIVIDER_SIGNED_EN
        run_op(-64'sd100, 32'd7);
        check("s_q1", bus.quotient, -64'sd14);
        run_op(64'd100, -32'sd7);
        check("s_q2", bus.quotient, -64'sd14);
        check("s_r2", 64'(bus.remainder), 64'd2);
        run_op(64'h8000_0000_0000_0000, 32'hFFFF_FFFF);
        check("s_wrap_q", bus.quotient, 64'h8000_0000_0000_0000);
        run_op(-64'sd5, 32'd0);
        check("s_dbz_q", bus.quotient, 64'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
